stopwatch_core: RTL and testbench

- Stopwatch engine that produces the packed BCD MM:SS value consumed by the 4-digit display driver and the LED mirror at top level.
- Sits between the button debouncers (upstream) and the display path (downstream).
- Takes debounced level signals, detects rising edges, and runs a run/pause/clear FSM.
- Advances a cascaded BCD counter from a prescaled timebase.

---
 rtl/stopwatch_pkg.sv | 18 +
 rtl/stopwatch_bcd_digit.sv | 35 +++
 rtl/stopwatch_core.sv | 165 ++++++++++++++++
 tb/tb_stopwatch_core.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUNNING = 2'd1,
      PAUSED  = 2'd2
   } state_t;

   localparam int DIGIT_W   = 4;
   localparam int UNITS_MAX = 9;
   localparam int TENS_MAX  = 5;

   localparam logic [4*DIGIT_W-1:0] NUMBER_RST = 16'h0000;

endpackage

// File: rtl/stopwatch_bcd_digit.sv
// One BCD digit 0..MAX that advances on inc and wraps to 0 with a carry out.
// Latency: digit updates on the clock edge after inc; carry is combinational.
// Backpressure: none, inc is a single-cycle strobe.
module bcd_digit
   import stopwatch_pkg::*;
#(
   parameter int MAX = UNITS_MAX
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               inc,
   output logic [DIGIT_W-1:0] digit,
   output logic               carry
);

   localparam logic [DIGIT_W-1:0] MAX_D = DIGIT_W'(MAX);

   if (MAX < 1 || MAX > UNITS_MAX) begin : g_max_chk
      $error("bcd_digit: MAX must be within 1..9");
   end

   assign carry = inc & (digit == MAX_D);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         digit <= '0;
      end else if (clr || carry) begin
         digit <= '0;
      end else if (inc) begin
         digit <= digit + DIGIT_W'(1);
      end
   end

endmodule

// File: rtl/stopwatch_core.sv
// MM:SS BCD stopwatch with run/pause/clear control; lap freeze under STOPWATCH_LAP_EN.
// Latency: a button level rising before edge N takes effect after edge N+1.
// Backpressure: none, inputs are debounced levels and outputs are free-running.
module stopwatch_core
   import stopwatch_pkg::*;
#(
   parameter int BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
   parameter int TICK_RATE_IN_HZ             = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_stop,
   input  logic        clear,
   input  logic        lap,
   output logic [15:0] number,
   output logic        running,
   output logic        rollover,
   output logic        lap_active
);

   localparam int DIV = BOARD_CLOCK_FREQUENCY_IN_HZ / TICK_RATE_IN_HZ;
   localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

   if (DIV < 2) begin : g_div_chk
      $error("stopwatch_core: clock/tick ratio must be at least 2");
   end

   state_t state, state_nx;

   logic [1:0] btn_q, btn_prev;
   logic       ss_edge, clr_edge;
   logic       zero_cnt, tick;
   logic [PW-1:0] presc;

   logic [DIGIT_W-1:0] s0, s1, m0, m1;
   logic               s0_c, s1_c, m0_c, m1_c;
   logic [15:0]        live;

   // Inputs are registered once before the history stage, so edges come from flops only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_q    <= '0;
         btn_prev <= '0;
      end else begin
         btn_q    <= {clear, start_stop};
         btn_prev <= btn_q;
      end
   end

   assign ss_edge  = btn_q[0] & ~btn_prev[0];
   assign clr_edge = btn_q[1] & ~btn_prev[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (ss_edge) state_nx = RUNNING;
         RUNNING: if (ss_edge) state_nx = PAUSED;
         PAUSED: begin
            if (clr_edge)     state_nx = IDLE;
            else if (ss_edge) state_nx = RUNNING;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      running  = 1'b0;
      zero_cnt = 1'b0;
      case (state)
         RUNNING: running  = 1'b1;
         IDLE,
         PAUSED:  zero_cnt = clr_edge;
         default: zero_cnt = 1'b0;
      endcase
   end

   assign tick = running & (presc == PRESC_LAST);

   // Held while paused so a resume finishes the partial second.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc <= '0;
      end else if (zero_cnt) begin
         presc <= '0;
      end else if (running) begin
         presc <= tick ? '0 : presc + PW'(1);
      end
   end

   bcd_digit #(.MAX(UNITS_MAX)) u_s0 (
      .clk(clk), .rst(rst), .clr(zero_cnt), .inc(tick), .digit(s0), .carry(s0_c)
   );
   bcd_digit #(.MAX(TENS_MAX)) u_s1 (
      .clk(clk), .rst(rst), .clr(zero_cnt), .inc(s0_c), .digit(s1), .carry(s1_c)
   );
   bcd_digit #(.MAX(UNITS_MAX)) u_m0 (
      .clk(clk), .rst(rst), .clr(zero_cnt), .inc(s1_c), .digit(m0), .carry(m0_c)
   );
   bcd_digit #(.MAX(TENS_MAX)) u_m1 (
      .clk(clk), .rst(rst), .clr(zero_cnt), .inc(m0_c), .digit(m1), .carry(m1_c)
   );

   assign live = {m1, m0, s1, s0};

   // Registered alongside the digits so the pulse coincides with 00:00 on number.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rollover <= 1'b0;
      end else begin
         rollover <= m1_c;
      end
   end

`ifdef STOPWATCH_LAP_EN
   logic        lap_q, lap_prev, lap_edge;
   logic        lap_r;
   logic [15:0] snap;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lap_q    <= 1'b0;
         lap_prev <= 1'b0;
      end else begin
         lap_q    <= lap;
         lap_prev <= lap_q;
      end
   end

   assign lap_edge = lap_q & ~lap_prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lap_r <= 1'b0;
         snap  <= NUMBER_RST;
      end else if (zero_cnt) begin
         lap_r <= 1'b0;
      end else if (running && lap_edge) begin
         if (!lap_r) begin
            snap  <= live;
            lap_r <= 1'b1;
         end else begin
            lap_r <= 1'b0;
         end
      end
   end

   assign number     = lap_r ? snap : live;
   assign lap_active = lap_r;
`else
   logic lap_unused;
   assign lap_unused = lap;
   assign number     = live;
   assign lap_active = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core at DIV=4: directed scenarios plus random button traffic,
// all compared each cycle against an elapsed-seconds reference model.
module tb_stopwatch_core;

   localparam int BOARD_HZ = 4;
   localparam int TICK_HZ  = 1;
   localparam int DIV      = BOARD_HZ / TICK_HZ;
`ifdef STOPWATCH_LAP_EN
   localparam bit LAP_ON = 1'b1;
`else
   localparam bit LAP_ON = 1'b0;
`endif

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_stop = 1'b0;
   logic        clear = 1'b0;
   logic        lap = 1'b0;
   logic [15:0] number;
   logic        running;
   logic        rollover;
   logic        lap_active;

   int checks = 0;
   int errors = 0;

   stopwatch_core #(
      .BOARD_CLOCK_FREQUENCY_IN_HZ(BOARD_HZ),
      .TICK_RATE_IN_HZ(TICK_HZ)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start_stop(start_stop),
      .clear(clear),
      .lap(lap),
      .number(number),
      .running(running),
      .rollover(rollover),
      .lap_active(lap_active)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int s);
      int m, sec;
      m   = s / 60;
      sec = s % 60;
      return {4'(m / 10), 4'(m % 10), 4'(sec / 10), 4'(sec % 10)};
   endfunction

   // Reference: elapsed whole seconds plus a sub-second phase, advanced per clock.
   int       m_mode = M_IDLE;
   int       m_secs = 0;
   int       m_sub = 0;
   int       m_lap_secs = 0;
   bit       m_frozen = 1'b0;
   bit       m_roll = 1'b0;
   bit [2:0] d1 = '0;
   bit [2:0] d2 = '0;

   always @(posedge clk or posedge rst) begin
      bit [2:0] e;
      bit       tk;
      if (rst) begin
         m_mode = M_IDLE; m_secs = 0; m_sub = 0; m_lap_secs = 0;
         m_frozen = 1'b0; m_roll = 1'b0; d1 = '0; d2 = '0;
      end else begin
         e      = d1 & ~d2;
         m_roll = 1'b0;
         tk     = (m_mode == M_RUN) && (m_sub == DIV - 1);
         if (LAP_ON && m_mode == M_RUN && e[2]) begin
            if (!m_frozen) begin
               m_frozen   = 1'b1;
               m_lap_secs = m_secs;
            end else begin
               m_frozen = 1'b0;
            end
         end
         if (m_mode == M_RUN) begin
            m_sub = (m_sub + 1) % DIV;
            if (tk) begin
               m_secs = (m_secs + 1) % 3600;
               m_roll = (m_secs == 0);
            end
         end
         case (m_mode)
            M_IDLE: if (e[0]) m_mode = M_RUN;
            M_RUN:  if (e[0]) m_mode = M_PAUSE;
            default: begin
               if (e[1]) begin
                  m_mode = M_IDLE; m_secs = 0; m_sub = 0; m_frozen = 1'b0;
               end else if (e[0]) begin
                  m_mode = M_RUN;
               end
            end
         endcase
         d2 = d1;
         d1 = {lap, clear, start_stop};
      end
   end

   always @(negedge clk) begin
      check("model_number", number, m_frozen ? to_bcd(m_lap_secs) : to_bcd(m_secs));
      check("model_running", 16'(running), 16'(m_mode == M_RUN));
      check("model_rollover", 16'(rollover), 16'(m_roll));
      check("model_lap_active", 16'(lap_active), 16'(m_frozen));
   end

   task automatic press(input int which);
      case (which)
         0: start_stop = 1'b1;
         1: clear = 1'b1;
         default: lap = 1'b1;
      endcase
      @(negedge clk);
      start_stop = 1'b0;
      clear = 1'b0;
      lap = 1'b0;
   endtask

   task automatic wait_number(input logic [15:0] v, input int budget);
      int n;
      n = 0;
      while (number !== v && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("wait_number", number, v);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      repeat (3) @(negedge clk);
      check("rst_number", number, 16'h0000);
      check("rst_running", 16'(running), 16'd0);
      check("rst_rollover", 16'(rollover), 16'd0);
      check("rst_lap_active", 16'(lap_active), 16'd0);
      #1 rst = 1'b0;
      @(negedge clk);

      // Start latency and first ticks
      press(0);
      check("start_not_yet", 16'(running), 16'd0);
      @(negedge clk);
      check("start_running", 16'(running), 16'd1);
      repeat (3) @(negedge clk);
      check("pre_first_tick", number, 16'h0000);
      @(negedge clk);
      check("first_tick", number, 16'h0001);
      repeat (36) @(negedge clk);
      check("ten_seconds", number, 16'h0010);

      // Clear ignored while running, then async reset mid-count
      repeat (8) @(negedge clk);
      check("at_12", number, 16'h0012);
      press(1);
      repeat (7) @(negedge clk);
      check("clear_ignored", number, 16'h0014);
      check("clear_ignored_run", 16'(running), 16'd1);
      #1 rst = 1'b1;
      #1;
      check("async_rst_number", number, 16'h0000);
      check("async_rst_running", 16'(running), 16'd0);
      @(negedge clk);
      #1 rst = 1'b0;
      @(negedge clk);

      // Pause preserves sub-second phase
      press(0);
      wait_number(16'h0003, 40);
      press(0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("paused_hold", number, 16'h0003);
         check("paused_running", 16'(running), 16'd0);
      end
      press(0);
      @(negedge clk);
      check("resume_running", 16'(running), 16'd1);
      @(negedge clk);
      check("resume_partial_a", number, 16'h0003);
      @(negedge clk);
      check("resume_partial_b", number, 16'h0004);

      // Start and clear together while paused: clear wins
      wait_number(16'h0007, 40);
      press(0);
      repeat (3) @(negedge clk);
      check("paused_at_7", number, 16'h0007);
      check("paused_at_7_run", 16'(running), 16'd0);
      start_stop = 1'b1;
      clear = 1'b1;
      @(negedge clk);
      start_stop = 1'b0;
      clear = 1'b0;
      @(negedge clk);
      check("both_clear_number", number, 16'h0000);
      check("both_clear_running", 16'(running), 16'd0);

`ifdef STOPWATCH_LAP_EN
      // Lap freeze for 12 ticks, then release
      @(negedge clk);
      press(0);
      wait_number(16'h0005, 60);
      press(2);
      for (int i = 0; i < 45; i++) begin
         @(negedge clk);
         check("lap_frozen", number, 16'h0005);
         check("lap_active_hi", 16'(lap_active), 16'd1);
      end
      press(2);
      @(negedge clk);
      check("lap_release", number, 16'h0017);
      check("lap_active_lo", 16'(lap_active), 16'd0);
`endif

      // Full wrap 59:59 -> 00:00
      do_reset();
      press(0);
      wait_number(16'h5958, 15000);
      wait_number(16'h5959, 8);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("hold_5959", number, 16'h5959);
         check("no_roll_yet", 16'(rollover), 16'd0);
      end
      @(negedge clk);
      check("wrap_number", number, 16'h0000);
      check("wrap_rollover", 16'(rollover), 16'd1);
      check("wrap_running", 16'(running), 16'd1);
      @(negedge clk);
      check("roll_one_cycle", 16'(rollover), 16'd0);
      check("after_wrap_running", 16'(running), 16'd1);

      // Random button traffic with occasional resets
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         #1;
         if ($urandom_range(0, 11) == 0) start_stop = ~start_stop;
         if ($urandom_range(0, 29) == 0) clear = ~clear;
         if ($urandom_range(0, 13) == 0) lap = ~lap;
         rst = ($urandom_range(0, 1499) == 0);
      end
      @(negedge clk);
      #1 rst = 1'b0;
      repeat (4) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
